// File: rtl/wave_recorder_if.sv
// Stream-in / RAM-write-out bundle of the WAV recorder.
interface wave_recorder_if #(
    parameter int unsigned ADDR_W = 17
);
    logic              I_START;
    logic              I_STOP;
    logic [15:0]       I_SND;
    logic [ADDR_W-1:0] O_WR_ADDR;
    logic [7:0]        O_WR_DATA;
    logic              O_WR_EN;
    logic              O_BUSY;
    logic              O_DONE;
    logic [31:0]       O_DATA_SIZE;

    modport master (
        output I_START, I_STOP, I_SND,
        input  O_WR_ADDR, O_WR_DATA, O_WR_EN, O_BUSY, O_DONE, O_DATA_SIZE
    );
    modport slave (
        input  I_START, I_STOP, I_SND,
        output O_WR_ADDR, O_WR_DATA, O_WR_EN, O_BUSY, O_DONE, O_DATA_SIZE
    );
endinterface

// File: rtl/wave_recorder.sv
// Records a signed 16-bit audio stream into byte RAM as a mono PCM WAV image:
// samples from byte 44 during capture, then the 44-byte header once the size is known.
module wave_recorder #(
    parameter int unsigned CLK_SPEED   = 24000000,
    parameter int unsigned SAMPLE_RATE = 48000,
    parameter int unsigned BITS        = 16,
    parameter int unsigned ADDR_W      = 17
) (
    input  logic           I_CLK,
    input  logic           I_RST,
    wave_recorder_if.slave bus
);
    localparam int unsigned     DIV   = CLK_SPEED / SAMPLE_RATE;
    localparam int unsigned     DIV_W = $clog2(DIV);
    localparam int unsigned     BPS   = BITS / 8;
    localparam int unsigned     HDR_B = 44;
    localparam longint unsigned CAP   = 64'd1 << ADDR_W;
    localparam logic [31:0]     MAXB  = 32'((CAP - 64'(HDR_B)) / 64'(BPS) * 64'(BPS));

    typedef enum logic [1:0] {ST_IDLE, ST_CAPTURE, ST_HEADER, ST_DONE} state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               start_prev_q, start_prev_d;
    logic [7:0]         snd_hi_q, snd_hi_d;
    logic               hi_pend_q, hi_pend_d;
    logic [5:0]         hdr_idx_q, hdr_idx_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [7:0]         wr_data_q, wr_data_d;
    logic               wr_en_q, wr_en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [31:0]        data_size_q, data_size_d;
    logic               tick;
    logic [ADDR_W-1:0]  data_addr;

    // Header byte at offset idx; words are little-endian, ASCII tags pre-swapped.
    function automatic logic [7:0] hdr_byte(input logic [5:0] idx, input logic [31:0] size);
        logic [31:0] word;
        case (idx[5:2])
            4'd0:    word = 32'h4646_4952;
            4'd1:    word = size + 32'd36;
            4'd2:    word = 32'h4556_4157;
            4'd3:    word = 32'h2074_6D66;
            4'd4:    word = 32'd16;
            4'd5:    word = 32'h0001_0001;
            4'd6:    word = 32'(SAMPLE_RATE);
            4'd7:    word = 32'(SAMPLE_RATE * BPS);
            4'd8:    word = {16'(BITS), 16'(BPS)};
            4'd9:    word = 32'h6174_6164;
            default: word = size;
        endcase
        return 8'(word >> {idx[1:0], 3'b000});
    endfunction

    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        start_prev_d = bus.I_START;
        snd_hi_d     = snd_hi_q;
        hi_pend_d    = 1'b0;
        hdr_idx_d    = hdr_idx_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        wr_en_d      = 1'b0;
        data_size_d  = data_size_q;
        tick         = (div_q == DIV_W'(DIV - 1));
        data_addr    = ADDR_W'(data_size_q + 32'(HDR_B));

        case (state_q)
            ST_IDLE: begin
                if (bus.I_START && !start_prev_q) begin
                    state_d     = ST_CAPTURE;
                    div_d       = '0;
                    data_size_d = '0;
                    hdr_idx_d   = '0;
                end
            end
            ST_CAPTURE: begin
                div_d = tick ? '0 : div_q + DIV_W'(1);
                // A pending high byte always lands, even when stop arrives with it.
                if (hi_pend_q) begin
                    wr_en_d     = 1'b1;
                    wr_addr_d   = data_addr;
                    wr_data_d   = snd_hi_q;
                    data_size_d = data_size_q + 32'd1;
                    if (bus.I_STOP) state_d = ST_HEADER;
                end else if (bus.I_STOP) begin
                    state_d = ST_HEADER;
                end else if (tick) begin
                    if (data_size_q == MAXB) begin
                        state_d = ST_HEADER;
                    end else begin
                        wr_en_d     = 1'b1;
                        wr_addr_d   = data_addr;
                        data_size_d = data_size_q + 32'd1;
                        snd_hi_d    = bus.I_SND[15:8];
                        if (BITS == 8) begin
                            wr_data_d = bus.I_SND[15:8] ^ 8'h80;
                        end else begin
                            wr_data_d = bus.I_SND[7:0];
                            hi_pend_d = 1'b1;
                        end
                    end
                end
            end
            ST_HEADER: begin
                wr_en_d   = 1'b1;
                wr_addr_d = ADDR_W'(hdr_idx_q);
                wr_data_d = hdr_byte(hdr_idx_q, data_size_q);
                hdr_idx_d = hdr_idx_q + 6'd1;
                if (hdr_idx_q == 6'(HDR_B - 1)) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_CAPTURE) || (state_d == ST_HEADER);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            state_q      <= ST_IDLE;
            div_q        <= '0;
            start_prev_q <= 1'b0;
            snd_hi_q     <= '0;
            hi_pend_q    <= 1'b0;
            hdr_idx_q    <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            data_size_q  <= '0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            start_prev_q <= start_prev_d;
            snd_hi_q     <= snd_hi_d;
            hi_pend_q    <= hi_pend_d;
            hdr_idx_q    <= hdr_idx_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_en_q      <= wr_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            data_size_q  <= data_size_d;
        end
    end

    assign bus.O_WR_ADDR   = wr_addr_q;
    assign bus.O_WR_DATA   = wr_data_q;
    assign bus.O_WR_EN     = wr_en_q;
    assign bus.O_BUSY      = busy_q;
    assign bus.O_DONE      = done_q;
    assign bus.O_DATA_SIZE = data_size_q;
endmodule

// File: tb/tb_wave_recorder.sv
// Three recorders (16-bit, 8-bit, 16-bit with a 128-byte RAM) driven by one stream
// and checked against a WAV-image model built from sample lists.
module tb_wave_recorder;
    localparam int SR   = 100;
    localparam int DIV  = 4;
    localparam int NDUT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stop;
    logic [15:0] snd;
    always #5 clk = ~clk;

    wave_recorder_if #(.ADDR_W(17)) if16 ();
    wave_recorder_if #(.ADDR_W(17)) if8 ();
    wave_recorder_if #(.ADDR_W(7))  if7 ();

    wave_recorder #(.CLK_SPEED(400), .SAMPLE_RATE(SR), .BITS(16), .ADDR_W(17))
        dut16 (.I_CLK(clk), .I_RST(rst), .bus(if16));
    wave_recorder #(.CLK_SPEED(400), .SAMPLE_RATE(SR), .BITS(8), .ADDR_W(17))
        dut8 (.I_CLK(clk), .I_RST(rst), .bus(if8));
    wave_recorder #(.CLK_SPEED(400), .SAMPLE_RATE(SR), .BITS(16), .ADDR_W(7))
        dut7 (.I_CLK(clk), .I_RST(rst), .bus(if7));

    assign if16.I_START = start; assign if16.I_STOP = stop; assign if16.I_SND = snd;
    assign if8.I_START  = start; assign if8.I_STOP  = stop; assign if8.I_SND  = snd;
    assign if7.I_START  = start; assign if7.I_STOP  = stop; assign if7.I_SND  = snd;

    logic        mon_en   [NDUT];
    logic [16:0] mon_addr [NDUT];
    logic [7:0]  mon_data [NDUT];
    logic        mon_done [NDUT];
    logic        mon_busy [NDUT];
    logic [31:0] mon_size [NDUT];
    assign mon_en[0] = if16.O_WR_EN; assign mon_addr[0] = if16.O_WR_ADDR; assign mon_data[0] = if16.O_WR_DATA;
    assign mon_en[1] = if8.O_WR_EN;  assign mon_addr[1] = if8.O_WR_ADDR;  assign mon_data[1] = if8.O_WR_DATA;
    assign mon_en[2] = if7.O_WR_EN;  assign mon_addr[2] = 17'(if7.O_WR_ADDR); assign mon_data[2] = if7.O_WR_DATA;
    assign mon_done[0] = if16.O_DONE; assign mon_busy[0] = if16.O_BUSY; assign mon_size[0] = if16.O_DATA_SIZE;
    assign mon_done[1] = if8.O_DONE;  assign mon_busy[1] = if8.O_BUSY;  assign mon_size[1] = if8.O_DATA_SIZE;
    assign mon_done[2] = if7.O_DONE;  assign mon_busy[2] = if7.O_BUSY;  assign mon_size[2] = if7.O_DATA_SIZE;

    // RAM images plus the cycle each byte was last written.
    int         cyc = 0;
    logic [7:0] img  [NDUT][256];
    int         t_wr [NDUT][256];
    int         wr_cnt [NDUT];
    int         done_cnt [NDUT];
    int         done_cyc [NDUT];
    initial for (int d = 0; d < NDUT; d++) begin wr_cnt[d] = 0; done_cnt[d] = 0; done_cyc[d] = 0; end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            if (mon_en[d] === 1'b1) begin
                wr_cnt[d] = wr_cnt[d] + 1;
                if (mon_addr[d] < 17'd256) begin
                    img[d][mon_addr[d][7:0]]  = mon_data[d];
                    t_wr[d][mon_addr[d][7:0]] = cyc;
                end
            end
            if (mon_done[d] === 1'b1) begin
                done_cnt[d] = done_cnt[d] + 1;
                done_cyc[d] = cyc;
            end
        end
    end

    int nchk = 0;
    int nerr = 0;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    logic [7:0] exp_hdr [44];
    function automatic void put_str(input int off, input string s);
        for (int i = 0; i < 4; i++) exp_hdr[off+i] = s[i];
    endfunction
    function automatic void put_le(input int off, input int n, input longint v);
        for (int i = 0; i < n; i++) exp_hdr[off+i] = 8'(v >> (8*i));
    endfunction
    function automatic void build_hdr(input int sz, input int bits);
        put_str(0, "RIFF"); put_le(4, 4, longint'(sz) + 36); put_str(8, "WAVE");
        put_str(12, "fmt "); put_le(16, 4, 16); put_le(20, 2, 1); put_le(22, 2, 1);
        put_le(24, 4, SR); put_le(28, 4, SR * bits / 8); put_le(32, 2, bits / 8);
        put_le(34, 2, bits); put_str(36, "data"); put_le(40, 4, sz);
    endfunction

    int c0;
    int esz [NDUT];

    // One recording: stop is first seen at edge stop_at; start re-pulses while busy.
    task automatic run_rec(input int stop_at, input bit rnd, input logic [15:0] fixed);
        logic [15:0] smp[$];
        int base_wr [NDUT];
        int base_dn [NDUT];
        bit stopped = 1'b0;
        bit all;
        int bits, bad, ns;
        logic [7:0] eb;
        for (int d = 0; d < NDUT; d++) begin base_wr[d] = wr_cnt[d]; base_dn[d] = done_cnt[d]; end
        @(posedge clk); #1;
        c0 = cyc;
        for (int e = 1; e <= stop_at; e++) begin
            start = (e <= 3) || (e >= 6 && e <= 8);
            stop  = (e >= stop_at);
            snd   = rnd ? 16'($urandom) : fixed;
            @(posedge clk);
            if (stop) stopped = 1'b1;
            if (!stopped && e > 1 && (e - 1) % DIV == 0) smp.push_back(snd);
            #1;
        end
        start = 1'b0; stop = 1'b0;
        for (int w = 0; w < 400; w++) begin
            all = 1'b1;
            for (int d = 0; d < NDUT; d++)
                if (done_cnt[d] == base_dn[d] || mon_busy[d] !== 1'b0) all = 1'b0;
            if (all) break;
            @(posedge clk); #1;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            bits = (d == 1) ? 8 : 16;
            ns   = (d == 2 && smp.size() > 42) ? 42 : smp.size();
            esz[d] = ns * bits / 8;
            check($sformatf("d%0d_done_pulses", d), 64'(done_cnt[d] - base_dn[d]), 64'd1);
            check($sformatf("d%0d_busy_end", d), 64'(mon_busy[d]), 64'd0);
            check($sformatf("d%0d_data_size", d), 64'(mon_size[d]), 64'(esz[d]));
            check($sformatf("d%0d_write_count", d), 64'(wr_cnt[d] - base_wr[d]), 64'(44 + esz[d]));
            build_hdr(esz[d], bits);
            bad = 0;
            for (int a = 0; a < 44; a++)
                if (t_wr[d][a] <= c0 || img[d][a] !== exp_hdr[a]) bad++;
            check($sformatf("d%0d_header_bad_bytes", d), 64'(bad), 64'd0);
            bad = 0;
            for (int j = 0; j < esz[d] && j < 200; j++) begin
                if (bits == 8) eb = smp[j][15:8] ^ 8'h80;
                else eb = (j % 2 == 0) ? smp[j/2][7:0] : smp[j/2][15:8];
                if (t_wr[d][44+j] <= c0 || img[d][44+j] !== eb) bad++;
            end
            check($sformatf("d%0d_data_bad_bytes", d), 64'(bad), 64'd0);
            check($sformatf("d%0d_header_span", d), 64'(t_wr[d][43] - t_wr[d][0]), 64'd43);
            check($sformatf("d%0d_done_after_hdr", d),
                  64'((done_cyc[d] - t_wr[d][43] == 0) || (done_cyc[d] - t_wr[d][43] == 1)), 64'd1);
            if (esz[d] >= 1) check($sformatf("d%0d_first_write_cyc", d), 64'(t_wr[d][44] - c0), 64'd5);
            if (bits == 16 && esz[d] >= 4) begin
                check($sformatf("d%0d_hi_byte_cyc", d), 64'(t_wr[d][45] - c0), 64'd6);
                check($sformatf("d%0d_sample2_cyc", d), 64'(t_wr[d][46] - c0), 64'd9);
            end
            if (bits == 8 && esz[d] >= 2) check($sformatf("d%0d_sample2_cyc", d), 64'(t_wr[d][45] - c0), 64'd9);
        end
    endtask

    typedef struct {
        logic [15:0] snd;
        logic [7:0]  b8;
        logic [7:0]  lo;
        logic [7:0]  hi;
    } vec_t;
    vec_t vt [6];

    int bw [NDUT];
    int bd [NDUT];

    initial begin
        vt[0] = '{16'h8000, 8'h00, 8'h00, 8'h80};
        vt[1] = '{16'h7F00, 8'hFF, 8'h00, 8'h7F};
        vt[2] = '{16'h0000, 8'h80, 8'h00, 8'h00};
        vt[3] = '{16'h1234, 8'h92, 8'h34, 8'h12};
        vt[4] = '{16'hFFFF, 8'h7F, 8'hFF, 8'hFF};
        vt[5] = '{16'hA55A, 8'h25, 8'h5A, 8'hA5};

        rst = 1'b1; start = 1'b0; stop = 1'b0; snd = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < NDUT; d++)
            check($sformatf("d%0d_reset_outputs", d),
                  64'({mon_addr[d], mon_data[d], mon_en[d], mon_busy[d], mon_done[d], mon_size[d]}), 64'd0);
        @(posedge clk); #1; rst = 1'b0;
        repeat (2) @(posedge clk);

        // Vector table: one sample per recording, stop one cycle after its tick.
        for (int i = 0; i < 6; i++) begin
            run_rec(6, 1'b0, vt[i].snd);
            check($sformatf("vec%0d_b16_lo", i), 64'(img[0][44]), 64'(vt[i].lo));
            check($sformatf("vec%0d_b16_hi", i), 64'(img[0][45]), 64'(vt[i].hi));
            check($sformatf("vec%0d_b8", i),     64'(img[1][44]), 64'(vt[i].b8));
        end

        // Stop after three ticks' worth of bytes: header constants.
        run_rec(14, 1'b0, 16'h1234);
        check("hdr_riff", 64'({img[0][3], img[0][2], img[0][1], img[0][0]}), 64'h46464952);
        check("hdr_b4",  64'(img[0][4]),  64'h2A);
        check("hdr_b24", 64'(img[0][24]), 64'h64);
        check("hdr_b28", 64'(img[0][28]), 64'hC8);
        check("hdr_b32", 64'(img[0][32]), 64'h02);
        check("hdr_b34", 64'(img[0][34]), 64'h10);
        check("hdr_b40", 64'(img[0][40]), 64'h06);
        check("size_stop_after_tick", 64'(if16.O_DATA_SIZE), 64'd6);

        // Stop coincident with the third tick discards that sample.
        run_rec(13, 1'b0, 16'h5555);
        check("size_stop_on_tick", 64'(if16.O_DATA_SIZE), 64'd4);

        // Zero-sample recording.
        run_rec(2, 1'b0, 16'h0);
        check("size_zero", 64'(if16.O_DATA_SIZE), 64'd0);

        for (int r = 0; r < 6; r++) run_rec(int'($urandom_range(1, 40)), 1'b1, 16'h0);

        // Long run: the 128-byte RAM fills and auto-stops.
        run_rec(200, 1'b1, 16'h0);
        check("small_ram_size", 64'(if7.O_DATA_SIZE), 64'd84);
        check("small_ram_b40", 64'(img[2][40]), 64'd84);
        check("small_ram_last_addr", 64'(t_wr[2][127] > c0), 64'd1);

        // Reset mid-capture aborts with no header.
        for (int d = 0; d < NDUT; d++) bw[d] = wr_cnt[d];
        @(posedge clk); #1; start = 1'b1; snd = 16'h4321;
        repeat (8) begin @(posedge clk); #1; end
        start = 1'b0;
        check("pre_reset_writes16", 64'(wr_cnt[0] - bw[0]), 64'd2);
        check("pre_reset_writes8",  64'(wr_cnt[1] - bw[1]), 64'd1);
        rst = 1'b1; #1;
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("d%0d_rst_wr_en", d), 64'(mon_en[d]), 64'd0);
            check($sformatf("d%0d_rst_busy", d), 64'(mon_busy[d]), 64'd0);
            bw[d] = wr_cnt[d]; bd[d] = done_cnt[d];
        end
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("d%0d_post_rst_writes", d), 64'(wr_cnt[d] - bw[d]), 64'd0);
            check($sformatf("d%0d_post_rst_done", d), 64'(done_cnt[d] - bd[d]), 64'd0);
            check($sformatf("d%0d_post_rst_size", d), 64'(mon_size[d]), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
